// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving a CPU port (A) and a DMA/debug port (B) shared access to a data memory.
// Define DMEM_ALIGN_CHECK_EN to also reject misaligned and out-of-range accesses.
module dmem_arbiter #(
    parameter int unsigned ADDR_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_size,
    input  logic        a_unsigned,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic        b_unsigned,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_half_word_mode,
    output logic        mem_byte_mode,
    output logic        mem_unsigned_mode,
    input  logic [31:0] mem_data_out,
    output logic        busy,
    output logic        grant,
    output logic [1:0]  dbg_state
);
    // Handshake: a requester raises req with stable fields and holds them until its ack
    // pulses for one cycle; rdata/err are valid in that ack cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t      state;
    logic        last_b;
    logic        pick_b;
    logic        sel_we;
    logic        sel_uns;
    logic        sel_reject;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic [2:0]  sel_bytes;
`endif

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        // On a tie the requester that was not served last wins.
        pick_b    = b_req && (!a_req || !last_b);
        sel_we    = pick_b ? b_we       : a_we;
        sel_uns   = pick_b ? b_unsigned : a_unsigned;
        sel_size  = pick_b ? b_size     : a_size;
        sel_addr  = pick_b ? b_addr     : a_addr;
        sel_wdata = pick_b ? b_wdata    : a_wdata;
        sel_reject = (sel_size == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
        sel_bytes = (sel_size == 2'b00) ? 3'd4 : (sel_size == 2'b01) ? 3'd2 : 3'd1;
        if (sel_size == 2'b00 && sel_addr[1:0] != 2'b00) sel_reject = 1'b1;
        if (sel_size == 2'b01 && sel_addr[0]) sel_reject = 1'b1;
        if (({1'b0, sel_addr} + 33'(sel_bytes)) > 33'(ADDR_BYTES)) sel_reject = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            last_b             <= 1'b1;
            grant              <= 1'b0;
            a_ack              <= 1'b0;
            a_err              <= 1'b0;
            a_rdata            <= 32'd0;
            b_ack              <= 1'b0;
            b_err              <= 1'b0;
            b_rdata            <= 32'd0;
            mem_address        <= 32'd0;
            mem_data_in        <= 32'd0;
            mem_read           <= 1'b0;
            mem_write          <= 1'b0;
            mem_half_word_mode <= 1'b0;
            mem_byte_mode      <= 1'b0;
            mem_unsigned_mode  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grant  <= pick_b;
                        last_b <= pick_b;
                        if (sel_reject) begin
                            state <= RESP;
                            a_ack <= !pick_b;
                            a_err <= !pick_b;
                            b_ack <= pick_b;
                            b_err <= pick_b;
                        end else begin
                            state              <= ISSUE;
                            mem_address        <= sel_addr;
                            mem_data_in        <= sel_wdata;
                            mem_write          <= sel_we;
                            mem_read           <= !sel_we;
                            mem_half_word_mode <= (sel_size == 2'b01);
                            mem_byte_mode      <= (sel_size == 2'b10);
                            mem_unsigned_mode  <= sel_uns;
                        end
                    end
                end
                ISSUE: begin
                    // Writes commit on this edge; reads need one more cycle for the memory's registered output.
                    if (mem_write) begin
                        state              <= RESP;
                        a_ack              <= !grant;
                        b_ack              <= grant;
                        mem_address        <= 32'd0;
                        mem_data_in        <= 32'd0;
                        mem_write          <= 1'b0;
                        mem_half_word_mode <= 1'b0;
                        mem_byte_mode      <= 1'b0;
                        mem_unsigned_mode  <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state <= RESP;
                    if (grant) begin
                        b_ack   <= 1'b1;
                        b_rdata <= mem_data_out;
                    end else begin
                        a_ack   <= 1'b1;
                        a_rdata <= mem_data_out;
                    end
                    mem_address        <= 32'd0;
                    mem_data_in        <= 32'd0;
                    mem_read           <= 1'b0;
                    mem_half_word_mode <= 1'b0;
                    mem_byte_mode      <= 1'b0;
                    mem_unsigned_mode  <= 1'b0;
                end
                RESP: begin
                    state <= IDLE;
                    a_ack <= 1'b0;
                    a_err <= 1'b0;
                    b_ack <= 1'b0;
                    b_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
